// File: rtl/tetris_pkg.sv
// Shared board constants, cell addressing and line-clear FSM state encoding.
package tetris_pkg;

  localparam int unsigned BOARD_COLS  = 10;
  localparam int unsigned BOARD_ROWS  = 20;
  localparam int unsigned EMPTY_CELL  = 0;
  localparam int unsigned CELL_ADDR_W = 16;

  // Line-clear sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_DECIDE = 3'd2,
    ST_COPY   = 3'd3,
    ST_FILL   = 3'd4,
    ST_FINISH = 3'd5
  } lcc_state_e;

  // Linear cell address on the default board: row*BOARD_COLS + col
  function automatic logic [CELL_ADDR_W-1:0] addr(input logic [CELL_ADDR_W-1:0] row,
                                                  input logic [CELL_ADDR_W-1:0] col);
    return row * CELL_ADDR_W'(BOARD_COLS) + col;
  endfunction

endpackage

// File: rtl/row_full_check.sv
// Accumulates "every cell occupied" over the words of one board row.
module row_full_check
  import tetris_pkg::*;
#(
  parameter int unsigned COL_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [COL_W-1:0] q,
  output logic             full
);

  // Clear arms the flag; each valid word keeps it only if the cell is occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b1;
    end else if (valid) begin
      full <= full & (q != COL_W'(EMPTY_CELL));
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Bottom-up full-row detection, in-place downward compaction and top zero-fill
// of the board RAM, reporting the number of rows removed.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned COLS   = BOARD_COLS,
  parameter int unsigned ROWS   = BOARD_ROWS,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned COL_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        lines_cleared,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [COL_W-1:0]  ram_wdata,
  output logic              ram_wren,
  input  logic [COL_W-1:0]  ram_q
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CNT_W = $clog2(COLS + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0] COL_END  = CNT_W'(COLS);

  lcc_state_e       state;
  logic [ROW_W-1:0] src;
  logic [ROW_W-1:0] dst;
  logic [CNT_W-1:0] col;
  logic [4:0]       count;
  logic             wr_phase;
  logic             wren_q;
  logic             full;

  logic             chk_clear_c;
  logic             chk_valid_c;
  logic [4:0]       count_inc_c;
  logic [CNT_W-1:0] col_inc_c;
  logic [ROW_W-1:0] src_dec_c;
  logic [ROW_W-1:0] dst_dec_c;

  // Cell address at RAM width; constant-by-variable multiply
  function automatic logic [ADDR_W-1:0] cell_at(input logic [ROW_W-1:0] r,
                                                input logic [CNT_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Row check: col 0 arms the flag, cols 1..COLS carry the returned words
  assign chk_clear_c = (state == ST_CHECK) && (col == '0);
  assign chk_valid_c = (state == ST_CHECK) && (col != '0);

  assign count_inc_c = count + 5'd1;
  assign col_inc_c   = col + CNT_W'(1);
  assign src_dec_c   = src - ROW_W'(1);
  assign dst_dec_c   = dst - ROW_W'(1);

  // Write strobe drops in the very cycle reset is raised so an aborted pass
  // cannot land one more write
  assign ram_wren  = wren_q & ~reset;

  // Copy data is the word read in the preceding RD cycle; fill writes empty
  assign ram_wdata = (!reset && state == ST_COPY && wr_phase) ? ram_q
                                                              : COL_W'(EMPTY_CELL);

  row_full_check #(
    .COL_W (COL_W)
  ) u_row_full_check (
    .clk   (clk),
    .reset (reset),
    .clear (chk_clear_c),
    .valid (chk_valid_c),
    .q     (ram_q),
    .full  (full)
  );

  // Sequencer: row scan, keep/skip decision, row copy, top fill, completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= 5'd0;
      ram_addr      <= '0;
      wren_q        <= 1'b0;
      src           <= ROW_LAST;
      dst           <= ROW_LAST;
      col           <= '0;
      count         <= 5'd0;
      wr_phase      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Accept a pass; lines_cleared keeps the previous result until done
        ST_IDLE: begin
          if (start) begin
            src      <= ROW_LAST;
            dst      <= ROW_LAST;
            count    <= 5'd0;
            col      <= '0;
            ram_addr <= cell_at(ROW_LAST, '0);
            busy     <= 1'b1;
            state    <= ST_CHECK;
          end
        end

        // Stream the src row addresses; the last word returns one cycle later
        ST_CHECK: begin
          if (col == COL_END) begin
            col   <= '0;
            state <= ST_DECIDE;
          end else begin
            col <= col_inc_c;
            if (col != COL_LAST) begin
              ram_addr <= cell_at(src, col_inc_c);
            end
          end
        end

        // Skip a full row, keep a row in place, or move it down to dst
        ST_DECIDE: begin
          if (!full && (dst != src)) begin
            col      <= '0;
            wr_phase <= 1'b0;
            ram_addr <= cell_at(src, '0);
            state    <= ST_COPY;
          end else begin
            if (full) begin
              count <= count_inc_c;
            end else if (dst != '0) begin
              dst <= dst_dec_c;
            end
            if (src != '0) begin
              src      <= src_dec_c;
              col      <= '0;
              ram_addr <= cell_at(src_dec_c, '0);
              state    <= ST_CHECK;
            end else if (full || (count != 5'd0)) begin
              // Full top row: dst is still the first row that needs clearing
              col      <= '0;
              ram_addr <= cell_at(dst, '0);
              wren_q   <= 1'b1;
              state    <= ST_FILL;
            end else begin
              done          <= 1'b1;
              lines_cleared <= count;
              state         <= ST_FINISH;
            end
          end
        end

        // Two cycles per cell: read (src,c), then write it to (dst,c)
        ST_COPY: begin
          if (!wr_phase) begin
            ram_addr <= cell_at(dst, col);
            wren_q   <= 1'b1;
            wr_phase <= 1'b1;
          end else begin
            wren_q   <= 1'b0;
            wr_phase <= 1'b0;
            if (col != COL_LAST) begin
              col      <= col_inc_c;
              ram_addr <= cell_at(src, col_inc_c);
            end else begin
              col <= '0;
              dst <= dst_dec_c;
              if (src != '0) begin
                src      <= src_dec_c;
                ram_addr <= cell_at(src_dec_c, '0);
                state    <= ST_CHECK;
              end else begin
                // A copy implies dst > src, so at least one row needs clearing
                ram_addr <= cell_at(dst_dec_c, '0);
                wren_q   <= 1'b1;
                state    <= ST_FILL;
              end
            end
          end
        end

        // Zero one cell per cycle from row dst up to row 0
        ST_FILL: begin
          if (col != COL_LAST) begin
            col      <= col_inc_c;
            ram_addr <= cell_at(dst, col_inc_c);
          end else begin
            col <= '0;
            if (dst != '0) begin
              dst      <= dst_dec_c;
              ram_addr <= cell_at(dst_dec_c, '0);
            end else begin
              wren_q        <= 1'b0;
              done          <= 1'b1;
              lines_cleared <= count;
              state         <= ST_FINISH;
            end
          end
        end

        // done is visible this cycle; hand the RAM back next cycle
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy   <= 1'b0;
          wren_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl with a behavioural board RAM.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  localparam int unsigned COLS   = BOARD_COLS;
  localparam int unsigned ROWS   = BOARD_ROWS;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned COL_W  = 6;

  typedef logic [CELLS-1:0][COL_W-1:0] board_t;

  typedef struct packed {
    logic [4:0]  lines;
    logic [31:0] cycles;
    logic [31:0] writes;
    logic [31:0] t0;
    logic [31:0] w0;
    board_t      board;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [4:0]        lines_cleared;
  logic [ADDR_W-1:0] ram_addr;
  logic [COL_W-1:0]  ram_wdata;
  logic              ram_wren;
  logic [COL_W-1:0]  ram_q;

  logic [COL_W-1:0]  mem [256];
  logic              ld_en = 1'b0;
  board_t            ld_board;

  int cyc      = 0;
  int wr_count = 0;
  int tests    = 0;
  int fails    = 0;
  exp_t sb[$];

  line_clear_ctrl #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_wren      (ram_wren),
    .ram_q         (ram_q)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with a one-cycle bulk load port
  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= ld_board[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  // Cycle and write counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wren === 1'b1) wr_count <= wr_count + 1;
  end

  // Monitor: on each done pulse pop the expectation and compare everything
  initial begin
    exp_t   e;
    board_t act;
    int     bad;
    bit     chk_width;
    chk_width = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_width) begin
        chk_width = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL done_width: done=%b busy=%b one cycle after done, required 0/0", done, busy);
        end
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
        end else begin
          e = sb.pop_front();
          chk_width = 1'b1;
          tests++;
          if (lines_cleared !== e.lines) begin
            fails++;
            $display("FAIL lines_cleared: got %0d, required %0d", lines_cleared, e.lines);
          end
          tests++;
          if (cyc - int'(e.t0) + 1 != int'(e.cycles)) begin
            fails++;
            $display("FAIL cycle_budget: done at cycle %0d, required %0d", cyc - int'(e.t0) + 1, e.cycles);
          end
          tests++;
          if (wr_count - int'(e.w0) != int'(e.writes)) begin
            fails++;
            $display("FAIL write_count: got %0d writes, required %0d", wr_count - int'(e.w0), e.writes);
          end
          for (int i = 0; i < CELLS; i++) act[i] = mem[i];
          tests++;
          if (act !== e.board) begin
            fails++;
            bad = 0;
            for (int i = CELLS - 1; i >= 0; i--) if (act[i] !== e.board[i]) bad = i;
            $display("FAIL board: cell (%0d,%0d) got %0d, required %0d",
                     bad / COLS, bad % COLS, act[bad], e.board[bad]);
          end
        end
      end
    end
  end

  function automatic board_t put(board_t b, int r, int c, logic [COL_W-1:0] v);
    board_t t;
    t = b;
    t[addr(16'(r), 16'(c))] = v;
    return t;
  endfunction

  function automatic board_t fill_row(board_t b, int r, int ncols, logic [COL_W-1:0] v);
    board_t t;
    t = b;
    for (int c = 0; c < ncols; c++) t = put(t, r, c, v);
    return t;
  endfunction

  task automatic load(input board_t b);
    @(negedge clk);
    ld_board = b;
    ld_en    = 1'b1;
    @(negedge clk);
    ld_en    = 1'b0;
  endtask

  // Issue one pass and queue its expected outcome
  task automatic run_pass(input board_t expb, input int lines, input int copied);
    exp_t e;
    int   n;
    @(negedge clk);
    e.lines  = 5'(lines);
    e.cycles = 32'(1 + ROWS * (COLS + 2) + 2 * COLS * copied + COLS * lines + 1);
    e.writes = 32'(COLS * (copied + lines));
    e.t0     = 32'(cyc);
    e.w0     = 32'(wr_count);
    e.board  = expb;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles, required one", n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    board_t b;
    board_t x;
    int     w0;

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, lines_cleared, ram_addr, ram_wdata, ram_wren} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b lines=%0d addr=%0d wdata=%0d wren=%b, required all 0",
               busy, done, lines_cleared, ram_addr, ram_wdata, ram_wren);
    end
    reset = 1'b0;

    // Empty board: no writes, 242 cycles
    b = '0;
    load(b);
    run_pass(b, 0, 0);

    // One full bottom row with a single cell above it
    b = '0;
    b = fill_row(b, 19, COLS, 6'd5);
    b = put(b, 18, 3, 6'd2);
    load(b);
    x = '0;
    x = put(x, 19, 3, 6'd2);
    run_pass(x, 1, 19);

    // Four stacked full rows under a nine-cell row
    b = '0;
    for (int r = 16; r < 20; r++) b = fill_row(b, r, COLS, 6'd7);
    b = fill_row(b, 15, 9, 6'd1);
    load(b);
    x = '0;
    x = fill_row(x, 19, 9, 6'd1);
    run_pass(x, 4, 16);

    // Full rows 19 and 17 with a distinct single cell in every other row
    b = '0;
    for (int r = 0; r < 19; r++) b = put(b, r, r % 10, 6'((r % 6) + 1));
    b = fill_row(b, 19, COLS, 6'd7);
    b = fill_row(b, 17, COLS, 6'd7);
    load(b);
    x = '0;
    x = put(x, 19, 8, 6'd1);
    for (int r = 2; r < 19; r++) x = put(x, r, (r - 2) % 10, 6'(((r - 2) % 6) + 1));
    run_pass(x, 2, 18);

    // Second start while busy, then reset during the first row copy
    b = '0;
    b = fill_row(b, 19, COLS, 6'd5);
    for (int c = 0; c < 9; c++) b = put(b, 18, c, 6'(c + 1));
    load(b);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w0 = wr_count;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    tests++;
    if (ram_wren !== 1'b1 || wr_count - w0 != 2) begin
      fails++;
      $display("FAIL copy_progress: wren=%b writes=%0d, required wren=1 writes=2", ram_wren, wr_count - w0);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (ram_wren !== 1'b0) begin
      fails++;
      $display("FAIL reset_wren_drop: got %b, required 0", ram_wren);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({busy, done, ram_wren, lines_cleared} !== '0 || wr_count - w0 != 2) begin
      fails++;
      $display("FAIL reset_abort: busy=%b done=%b wren=%b lines=%0d writes=%0d, required 0/0/0/0/2",
               busy, done, ram_wren, lines_cleared, wr_count - w0);
    end
    @(negedge clk);
    reset = 1'b0;
    x = '0;
    for (int c = 0; c < 9; c++) x = put(x, 19, c, 6'(c + 1));
    run_pass(x, 1, 19);

    // Completely full board
    for (int i = 0; i < CELLS; i++) b[i] = 6'((i % 63) + 1);
    load(b);
    x = '0;
    run_pass(x, 20, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
